// File: rtl/alu_div_nr_param.sv
// Sequential non-restoring divider, one quotient bit per cycle, signed or unsigned per operation.
// Result WIDTH+1 cycles after accept (divide-by-zero: next cycle); result held until out_ready.
`timescale 1ns/1ps
module alu_div_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   a_sh, m_ext, a_step, a_fix;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // A is a signed WIDTH+1 partial remainder; its sign picks add or subtract.
  assign a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign m_ext  = {1'b0, m_q};
  assign a_step = a_q[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
  assign a_fix  = a_q[WIDTH] ? (a_q + m_ext) : a_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          negq_d = dvd_neg ^ dvs_neg;
          negr_d = dvd_neg;
          q_d    = dvd_neg ? -dividend : dividend;
          m_d    = dvs_neg ? -divisor : divisor;
          a_d    = '0;
          cnt_d  = CW'(WIDTH);
          dbz_d  = (divisor == '0);
          ovf_d  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        a_d   = a_step;
        q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        a_d     = a_fix;
        quot_d  = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
